// File: rtl/doa_fine_scheduler.sv
// Fine-search sequencer: one engine run per coarse candidate, merging reported minima into a sorted top-NUM_SRC list.
// Optional feature: define DOA_DEDUP_EN to merge minima lying within 1 degree of an existing list entry.
module doa_fine_scheduler #(
  parameter int DOASEARCH_WIDTH = 48,
  parameter int LOCAL_MIN_DEPTH = 16,
  parameter int CAND_DEPTH      = 8,
  parameter int NUM_SRC         = 2,
  parameter int HALF_SPAN       = 10,
  parameter int ANGLE_MIN       = 0,
  parameter int ANGLE_MAX       = 360
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [$clog2(CAND_DEPTH+1)-1:0]         cand_count,
  input  logic [9:0]                              cand_angle [0:CAND_DEPTH-1],
  output logic                                    fs_start,
  output logic [9:0]                              fs_angle_min,
  output logic [9:0]                              fs_angle_max,
  input  logic                                    fs_done,
  input  logic signed [DOASEARCH_WIDTH-1:0]       fs_local_min [0:LOCAL_MIN_DEPTH-1],
  input  logic [9:0]                              fs_local_min_angle [0:LOCAL_MIN_DEPTH-1],
  input  logic [$clog2(LOCAL_MIN_DEPTH)-1:0]      fs_local_min_count,
  output logic [9:0]                              doa_angle [0:NUM_SRC-1],
  output logic signed [DOASEARCH_WIDTH-1:0]       doa_value [0:NUM_SRC-1],
  output logic [$clog2(NUM_SRC+1)-1:0]            doa_count,
  output logic                                    busy,
  output logic                                    done
);
  localparam int W   = DOASEARCH_WIDTH;
  localparam int CCW = $clog2(CAND_DEPTH + 1);
  localparam int IW  = $clog2(CAND_DEPTH);
  localparam int JW  = $clog2(LOCAL_MIN_DEPTH);
  localparam int CW  = $clog2(NUM_SRC + 1);
  localparam logic signed [10:0] SPAN_S = 11'(HALF_SPAN);
  localparam logic signed [10:0] AMIN_S = 11'(ANGLE_MIN);
  localparam logic signed [10:0] AMAX_S = 11'(ANGLE_MAX);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_SCAN, S_NEXT, S_DONE} state_t;

  state_t                state_q;
  logic [CCW-1:0]        cnt_q;
  logic [IW-1:0]         idx_q;
  logic [JW-1:0]         j_q;
  logic                  fs_start_q, busy_q, done_q;
  logic [9:0]            fs_min_q, fs_max_q;
  logic [9:0]            cand_ang_q [CAND_DEPTH];
  logic signed [W-1:0]   wl_val_q [NUM_SRC];
  logic [9:0]            wl_ang_q [NUM_SRC];
  logic [CW-1:0]         wl_cnt_q;
  logic [9:0]            doa_angle_q [NUM_SRC];
  logic signed [W-1:0]   doa_value_q [NUM_SRC];
  logic [CW-1:0]         doa_cnt_q;

  assign fs_start     = fs_start_q;
  assign fs_angle_min = fs_min_q;
  assign fs_angle_max = fs_max_q;
  assign doa_angle    = doa_angle_q;
  assign doa_value    = doa_value_q;
  assign doa_count    = doa_cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Window is computed signed so candidates near 0 clamp instead of wrapping.
  logic signed [10:0] cand_s, win_lo, win_hi;
  always_comb begin
    cand_s = signed'({1'b0, cand_ang_q[idx_q]});
    win_lo = cand_s - SPAN_S;
    win_hi = cand_s + SPAN_S;
    if (win_lo < AMIN_S) win_lo = AMIN_S;
    if (win_hi > AMAX_S) win_hi = AMAX_S;
  end

`ifdef DOA_DEDUP_EN
  function automatic logic ang_close(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a >= b) ? a - b : b - a;
    return d <= 10'd1;
  endfunction
  logic                hit;
  int                  hit_idx;
  logic signed [W-1:0] hit_val;
`endif

  logic signed [W-1:0] new_val;
  logic [9:0]          new_ang;
  logic signed [W-1:0] base_val [NUM_SRC];
  logic [9:0]          base_ang [NUM_SRC];
  logic signed [W-1:0] wl_val_d [NUM_SRC];
  logic [9:0]          wl_ang_d [NUM_SRC];
  logic [CW-1:0]       wl_cnt_d;
  int                  base_cnt, pos, cnt_n;
  logic                ins_en;

  always_comb begin
    new_val  = fs_local_min[j_q];
    new_ang  = fs_local_min_angle[j_q];
    base_val = wl_val_q;
    base_ang = wl_ang_q;
    base_cnt = int'(wl_cnt_q);
    ins_en   = 1'b1;
`ifdef DOA_DEDUP_EN
    hit = 1'b0; hit_idx = 0; hit_val = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (!hit && k < int'(wl_cnt_q) && ang_close(wl_ang_q[k], new_ang)) begin
        hit = 1'b1; hit_idx = k; hit_val = wl_val_q[k];
      end
    // A better value for a known peak is re-inserted after pulling the old slot out.
    if (hit) begin
      if (new_val < hit_val) begin
        for (int k = 0; k < NUM_SRC - 1; k++)
          if (k >= hit_idx) begin
            base_val[k] = wl_val_q[k+1];
            base_ang[k] = wl_ang_q[k+1];
          end
        base_cnt = base_cnt - 1;
      end else begin
        ins_en = 1'b0;
      end
    end
`endif
    pos = 0;
    for (int k = 0; k < NUM_SRC; k++)
      if (k < base_cnt && base_val[k] <= new_val) pos = k + 1;
    wl_val_d = base_val;
    wl_ang_d = base_ang;
    cnt_n    = base_cnt;
    if (ins_en && pos < NUM_SRC) begin
      for (int k = 1; k < NUM_SRC; k++)
        if (k > pos) begin
          wl_val_d[k] = base_val[k-1];
          wl_ang_d[k] = base_ang[k-1];
        end
      for (int k = 0; k < NUM_SRC; k++)
        if (k == pos) begin
          wl_val_d[k] = new_val;
          wl_ang_d[k] = new_ang;
        end
      cnt_n = (base_cnt < NUM_SRC) ? base_cnt + 1 : base_cnt;
    end
    wl_cnt_d = CW'(cnt_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      j_q        <= '0;
      fs_start_q <= 1'b0;
      fs_min_q   <= '0;
      fs_max_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wl_cnt_q   <= '0;
      doa_cnt_q  <= '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        doa_angle_q[k] <= '0;
        doa_value_q[k] <= '0;
      end
    end else begin
      fs_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          cnt_q    <= (cand_count > CCW'(CAND_DEPTH)) ? CCW'(CAND_DEPTH) : cand_count;
          idx_q    <= '0;
          wl_cnt_q <= '0;
          busy_q   <= 1'b1;
          state_q  <= (cand_count == '0) ? S_DONE : S_LAUNCH;
        end
        S_LAUNCH: begin
          fs_min_q   <= win_lo[9:0];
          fs_max_q   <= win_hi[9:0];
          fs_start_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        // fs_start_q high marks the first WAIT cycle, where a stale fs_done is ignored.
        S_WAIT: if (fs_done && !fs_start_q) begin
          j_q     <= '0;
          state_q <= (fs_local_min_count != '0) ? S_SCAN : S_NEXT;
        end
        S_SCAN: begin
          wl_cnt_q <= wl_cnt_d;
          if (j_q == fs_local_min_count - JW'(1)) state_q <= S_NEXT;
          else j_q <= j_q + JW'(1);
        end
        S_NEXT: begin
          if (CCW'(idx_q) + CCW'(1) == cnt_q) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_LAUNCH;
          end
        end
        S_DONE: begin
          doa_angle_q <= wl_ang_q;
          doa_value_q <= wl_val_q;
          doa_cnt_q   <= wl_cnt_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      for (int k = 0; k < CAND_DEPTH; k++) cand_ang_q[k] <= cand_angle[k];
    end
    if (state_q == S_SCAN) begin
      wl_val_q <= wl_val_d;
      wl_ang_q <= wl_ang_d;
    end
  end
endmodule

// File: tb/tb_doa_fine_scheduler.sv
// Scoreboard bench for doa_fine_scheduler: engine model, directed cases and randomized runs against a sort-based model.
module tb_doa_fine_scheduler;
  localparam int W = 48, LMD = 16, CD = 8, NS = 2, HS = 10, AMIN = 0, AMAX = 360;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_m = 1'b0, start_g = 1'b0, start;
  logic [3:0] cand_count = '0;
  logic [9:0] cand_angle [0:CD-1];
  logic fs_start;
  logic [9:0] fs_angle_min, fs_angle_max;
  logic fs_done = 1'b0;
  logic signed [W-1:0] fs_local_min [0:LMD-1];
  logic [9:0] fs_local_min_angle [0:LMD-1];
  logic [3:0] fs_local_min_count = '0;
  logic [9:0] doa_angle [0:NS-1];
  logic signed [W-1:0] doa_value [0:NS-1];
  logic [1:0] doa_count;
  logic busy, done;

  assign start = start_m | start_g;
  always #5 clk = ~clk;

  doa_fine_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_count(cand_count), .cand_angle(cand_angle),
    .fs_start(fs_start), .fs_angle_min(fs_angle_min), .fs_angle_max(fs_angle_max),
    .fs_done(fs_done), .fs_local_min(fs_local_min), .fs_local_min_angle(fs_local_min_angle),
    .fs_local_min_count(fs_local_min_count), .doa_angle(doa_angle), .doa_value(doa_value),
    .doa_count(doa_count), .busy(busy), .done(done)
  );

  int total = 0, bad = 0;
  int fs_pulses = 0;
  int run_id = 0;
  bit poke_start = 0;
  int plan_n [CD];
  int plan_lat [CD];
  longint plan_val [CD][LMD];
  int plan_ang [CD][LMD];
  int exp_lo_q[$], exp_hi_q[$], exp_cnt_q[$], exp_ang_q[$];
  longint exp_val_q[$];
  longint run_v[$];
  int run_a[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int win_lo(input int a);
    return (a - HS < AMIN) ? AMIN : a - HS;
  endfunction
  function automatic int win_hi(input int a);
    return (a + HS > AMAX) ? AMAX : a + HS;
  endfunction

  // Reference: stable sort of every reported minimum by value, keep the first NS.
  task automatic push_expect(input longint v[$], input int a[$]);
    bit taken [64];
    int cnt, best;
    cnt = 0;
    for (int i = 0; i < 64; i++) taken[i] = 0;
    for (int r = 0; r < NS; r++) begin
      best = -1;
      for (int i = 0; i < v.size(); i++)
        if (!taken[i] && (best < 0 || v[i] < v[best])) best = i;
      if (best >= 0) begin
        taken[best] = 1;
        exp_ang_q.push_back(a[best]);
        exp_val_q.push_back(v[best]);
        cnt++;
      end else begin
        exp_ang_q.push_back(0);
        exp_val_q.push_back(0);
      end
    end
    exp_cnt_q.push_back(cnt);
  endtask

  task automatic push_manual(input int cnt, input int a0, input longint v0, input int a1, input longint v1);
    exp_cnt_q.push_back(cnt);
    exp_ang_q.push_back(a0); exp_val_q.push_back(v0);
    exp_ang_q.push_back(a1); exp_val_q.push_back(v1);
  endtask

  task automatic add_min(input int c, input longint v, input int a);
    plan_val[c][plan_n[c]] = v;
    plan_ang[c][plan_n[c]] = a;
    plan_n[c]++;
    run_v.push_back(v);
    run_a.push_back(a);
  endtask

  task automatic clear_plan();
    for (int c = 0; c < CD; c++) begin plan_n[c] = 0; plan_lat[c] = 2; end
    run_v.delete(); run_a.delete();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    check("run_done", done, 1);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit poke, input bit timing);
    run_id++;
    poke_start = poke;
    cand_count = 4'(n);
    for (int c = 0; c < n; c++) begin
      exp_lo_q.push_back(win_lo(int'(cand_angle[c])));
      exp_hi_q.push_back(win_hi(int'(cand_angle[c])));
    end
    @(negedge clk); start_m = 1'b1;
    @(posedge clk); #1; start_m = 1'b0;
    if (timing) begin
      check("busy_cycle1", busy, 1);
      check("fs_start_cycle1", fs_start, 0);
      @(posedge clk); #1;
      check("fs_start_cycle2", fs_start, 1);
      check("win_min_cycle2", fs_angle_min, win_lo(int'(cand_angle[0])));
      check("win_max_cycle2", fs_angle_max, win_hi(int'(cand_angle[0])));
    end
    wait_done();
  endtask

  // Engine model: answers each fs_start after plan_lat cycles with the planned minima.
  initial begin : engine
    int li, last_run;
    li = 0; last_run = -1;
    forever begin
      @(negedge clk);
      if (fs_start) begin
        if (run_id != last_run) begin li = 0; last_run = run_id; end
        if (li < CD) begin
          repeat (plan_lat[li]) @(negedge clk);
          fs_local_min_count = 4'(plan_n[li]);
          for (int i = 0; i < LMD; i++) begin
            if (i < plan_n[li]) begin
              fs_local_min[i] = W'(plan_val[li][i]);
              fs_local_min_angle[i] = 10'(plan_ang[li][i]);
            end else begin
              fs_local_min[i] = -48'sd1000000;
              fs_local_min_angle[i] = 10'd999;
            end
          end
          fs_done = 1'b1;
          start_g = poke_start;
          @(negedge clk);
          fs_done = 1'b0;
          start_g = 1'b0;
          li++;
        end
      end
    end
  end

  initial begin : monitor
    int c;
    forever begin
      @(negedge clk);
      if (fs_start) begin
        fs_pulses++;
        if (exp_lo_q.size() == 0) check("unexpected_fs_start", 1, 0);
        else begin
          check("fs_angle_min", fs_angle_min, exp_lo_q.pop_front());
          check("fs_angle_max", fs_angle_max, exp_hi_q.pop_front());
        end
      end
      if (done) begin
        if (exp_cnt_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          c = exp_cnt_q.pop_front();
          check("doa_count", doa_count, c);
          for (int r = 0; r < NS; r++) begin
            if (r < c) begin
              check("doa_angle", doa_angle[r], exp_ang_q.pop_front());
              check("doa_value", doa_value[r], exp_val_q.pop_front());
            end else begin
              void'(exp_ang_q.pop_front());
              void'(exp_val_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int p0, n, base, k;
    logic signed [W-1:0] rv;
    for (int i = 0; i < CD; i++) cand_angle[i] = '0;
    for (int i = 0; i < LMD; i++) begin fs_local_min[i] = '0; fs_local_min_angle[i] = '0; end
    clear_plan();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fs_start", fs_start, 0);
    check("rst_doa_count", doa_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero candidates: done two cycles after start, no engine launch.
    p0 = fs_pulses;
    push_manual(0, 0, 0, 0, 0);
    cand_count = 4'd0;
    @(negedge clk); start_m = 1'b1;
    @(posedge clk); #1; start_m = 1'b0;
    check("c0_busy_cycle1", busy, 1);
    check("c0_done_cycle1", done, 0);
    @(posedge clk); #1;
    check("c0_done_cycle2", done, 1);
    @(negedge clk); @(negedge clk);
    check("c0_no_fs_start", fs_pulses - p0, 0);

    // Single candidate at 100.
    clear_plan(); cand_angle[0] = 10'd100;
    add_min(0, 500, 95); add_min(0, 200, 105);
    push_expect(run_v, run_a);
    run(1, 0, 1);

    // Windows clamped at both azimuth bounds.
    clear_plan(); cand_angle[0] = 10'd5; cand_angle[1] = 10'd355;
    push_expect(run_v, run_a);
    p0 = fs_pulses;
    run(2, 0, 0);
    check("clamp_fs_pulses", fs_pulses - p0, 2);

    // Three candidates, one minimum each; worst is dropped.
    clear_plan(); cand_angle[0] = 10'd30; cand_angle[1] = 10'd150; cand_angle[2] = 10'd270;
    add_min(0, 300, 30); add_min(1, 100, 150); add_min(2, 200, 270);
    push_expect(run_v, run_a);
    run(3, 1, 0);

    // Same peak reported by overlapping windows.
    clear_plan(); cand_angle[0] = 10'd118; cand_angle[1] = 10'd124;
    add_min(0, 50, 120); add_min(1, 50, 120); add_min(1, 80, 200);
`ifdef DOA_DEDUP_EN
    push_manual(2, 120, 50, 200, 80);
`else
    push_manual(2, 120, 50, 120, 50);
`endif
    run(2, 0, 0);

    // Reset while the engine is running.
    clear_plan(); cand_angle[0] = 10'd200; plan_lat[0] = 20; plan_n[0] = 1;
    plan_val[0][0] = 7; plan_ang[0][0] = 200;
    run_id++; poke_start = 0; cand_count = 4'd1;
    exp_lo_q.push_back(190); exp_hi_q.push_back(210);
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    k = 0;
    while (!fs_start && k < 50) begin @(negedge clk); k++; end
    check("rstrun_launch", fs_start, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_fs_start", fs_start, 0);
    check("mid_rst_win_min", fs_angle_min, 0);
    check("mid_rst_win_max", fs_angle_max, 0);
    check("mid_rst_doa_count", doa_count, 0);
    for (int r = 0; r < NS; r++) begin
      check("mid_rst_doa_angle", doa_angle[r], 0);
      check("mid_rst_doa_value", doa_value[r], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_idle", busy, 0);
    clear_plan(); cand_angle[0] = 10'd40;
    add_min(0, -3, 41);
    push_expect(run_v, run_a);
    run(1, 0, 1);

    // Randomized runs; angles spaced 3 apart so merging never applies.
    for (int r = 0; r < 24; r++) begin
      clear_plan();
      n = $urandom_range(1, CD);
      base = $urandom_range(0, 200);
      k = 0;
      for (int c = 0; c < n; c++) begin
        cand_angle[c] = 10'($urandom_range(0, 360));
        plan_lat[c] = $urandom_range(1, 4);
        for (int i = $urandom_range(0, 4); i > 0; i--) begin
          if (r % 2 == 1) rv = W'($signed($urandom_range(0, 16)) - 8);
          else rv = W'({$urandom(), $urandom()});
          add_min(c, longint'(rv), base + 3 * k);
          k++;
        end
      end
      push_expect(run_v, run_a);
      run(n, 1'($urandom_range(0, 1)), 1'(r % 4 == 0));
    end

    repeat (5) @(negedge clk);
    check("win_queue_drained", exp_lo_q.size(), 0);
    check("result_queue_drained", exp_cnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
